// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment display path: active-low segment
// patterns {a,b,c,d,e,f,g} for hex digits and the "all dark" values.
package seg7_pkg;

  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b1100000;
  localparam logic [6:0] SEG_C = 7'b0110001;
  localparam logic [6:0] SEG_D = 7'b1000010;
  localparam logic [6:0] SEG_E = 7'b0110000;
  localparam logic [6:0] SEG_F = 7'b0111000;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] AN_OFF    = 4'b1111;

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex_to_7seg
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  always_comb begin
    pattern = SEG_BLANK;
    case (nibble)
      4'h0: pattern = SEG_0;
      4'h1: pattern = SEG_1;
      4'h2: pattern = SEG_2;
      4'h3: pattern = SEG_3;
      4'h4: pattern = SEG_4;
      4'h5: pattern = SEG_5;
      4'h6: pattern = SEG_6;
      4'h7: pattern = SEG_7;
      4'h8: pattern = SEG_8;
      4'h9: pattern = SEG_9;
      4'hA: pattern = SEG_A;
      4'hB: pattern = SEG_B;
      4'hC: pattern = SEG_C;
      4'hD: pattern = SEG_D;
      4'hE: pattern = SEG_E;
      4'hF: pattern = SEG_F;
      default: pattern = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_display_16.sv
// Four-digit multiplexed common-anode display driver: scans data[15:0] as hex
// digits, one digit per REFRESH_COUNT clocks, with optional leading-zero blanking.
module seg7_display_16
  import seg7_pkg::*;
#(
  parameter int REFRESH_COUNT = 100000,
  parameter bit BLANK_LZ      = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data,
  input  logic        enable,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int CW = (REFRESH_COUNT > 1) ? $clog2(REFRESH_COUNT) : 1;

  logic [CW-1:0] tick_cnt;
  logic          tick;
  logic [1:0]    sel;
  logic [3:0]    nibble;
  logic [6:0]    pattern;
  logic [3:0]    blank;
  logic [3:0]    an_next;
  logic [6:0]    seg_next;

  assign tick = (tick_cnt == CW'(REFRESH_COUNT - 1));

  // Scan timing runs independently of enable so re-enabling resumes in phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
      sel      <= 2'd0;
    end else if (tick) begin
      tick_cnt <= '0;
      sel      <= sel + 2'd1;
    end else begin
      tick_cnt <= tick_cnt + CW'(1);
    end
  end

  // Digit k is blanked when it and every more significant nibble are zero.
  assign blank[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < 4; gi++) begin : g_blank
      assign blank[gi] = BLANK_LZ && (data[15:4*gi] == '0);
    end
  endgenerate

  always_comb begin
    nibble = data[3:0];
    case (sel)
      2'd0: nibble = data[3:0];
      2'd1: nibble = data[7:4];
      2'd2: nibble = data[11:8];
      2'd3: nibble = data[15:12];
      default: nibble = data[3:0];
    endcase
  end

  hex_to_7seg u_dec (
    .nibble  (nibble),
    .pattern (pattern)
  );

  always_comb begin
    an_next  = AN_OFF;
    seg_next = SEG_BLANK;
    if (enable && !blank[sel]) begin
      an_next  = ~(4'b0001 << sel);
      seg_next = pattern;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= AN_OFF;
      seg <= SEG_BLANK;
    end else begin
      an  <= an_next;
      seg <= seg_next;
    end
  end

  assign dp = 1'b1;

endmodule
